alarm_trigger: RTL

Alarm decision stage sitting directly downstream of the alarm-time loader. Compares the loaded alarm hour/minute against the running time-of-day, raises `ring` when they first coincide, and manages stop, snooze and auto-timeout through a four-state FSM clocked by the system clock and advanced by a 1 Hz `sec_tick` strobe.

---
 rtl/alarm_pkg.sv | 23 ++
 rtl/rise_detect.sv | 29 ++
 rtl/alarm_trigger.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Types and constants shared by the alarm loader, timekeeper and trigger stages.
// The state encoding is fixed because other stages decode it directly.
package alarm_pkg;

  localparam int unsigned TIME_W   = 6;
  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned MIN_MAX  = 59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_e;

  function automatic logic hm_equal(input logic [TIME_W-1:0] a_hour,
                                    input logic [TIME_W-1:0] a_min,
                                    input logic [TIME_W-1:0] b_hour,
                                    input logic [TIME_W-1:0] b_min);
    return (a_hour == b_hour) && (a_min == b_min);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: rise_o pulses for one cycle, one edge after d_i goes high.
module rise_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic prev_d, prev_q;
  logic rise_d, rise_q;

  always_comb begin
    prev_d = d_i;
    rise_d = d_i & ~prev_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm decision FSM: rings on the first cycle the time-of-day meets the alarm time,
// then handles stop, snooze and ring timeout in whole seconds of sec_tick.
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned SNOOZE_S       = 300,
  parameter int unsigned MAX_SNOOZES    = 3
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               sec_tick,
  input  logic                               alarm_en,
  input  logic [TIME_W-1:0]                  alarm_hour,
  input  logic [TIME_W-1:0]                  alarm_min,
  input  logic [TIME_W-1:0]                  time_hour,
  input  logic [TIME_W-1:0]                  time_min,
  input  logic                               snooze,
  input  logic                               stop,
  output logic                               ring,
  output logic                               snoozing,
  output logic [$clog2(MAX_SNOOZES+1)-1:0]   snoozes_left
);

  localparam int unsigned RingW   = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S) : 1;
  localparam int unsigned SnzCntW = $clog2(SNOOZE_S + 1);
  localparam int unsigned LeftW   = $clog2(MAX_SNOOZES + 1);

  localparam logic [RingW-1:0]   RingLast = RingW'(RING_TIMEOUT_S - 1);
  localparam logic [SnzCntW-1:0] SnzLoad  = SnzCntW'(SNOOZE_S);
  localparam logic [SnzCntW-1:0] SnzLast  = SnzCntW'(1);
  localparam logic [LeftW-1:0]   LeftLoad = LeftW'(MAX_SNOOZES);

  alarm_state_e       state_d, state_q;
  logic [RingW-1:0]   ring_cnt_d, ring_cnt_q;
  logic [SnzCntW-1:0] snz_cnt_d, snz_cnt_q;
  logic [LeftW-1:0]   left_d, left_q;
  logic               match, match_d, match_q;
  logic               ring_d, ring_q;
  logic               snoozing_d, snoozing_q;
  logic               fire;
  logic               snooze_rise, stop_rise;

  rise_detect u_snooze_rise (
    .clk_i  (clock),
    .rst_ni (reset),
    .d_i    (snooze),
    .rise_o (snooze_rise)
  );

  rise_detect u_stop_rise (
    .clk_i  (clock),
    .rst_ni (reset),
    .d_i    (stop),
    .rise_o (stop_rise)
  );

  assign match = hm_equal(time_hour, time_min, alarm_hour, alarm_min);
  // Only the first cycle of a matching minute fires; match_q resets high so 00:00 is quiet.
  assign fire  = match && !match_q;

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    left_d     = left_q;
    match_d    = match;

    if (!alarm_en) begin
      state_d    = IDLE;
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
      left_d     = LeftLoad;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARMED;
        end
        ARMED: begin
          if (fire) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
          end
        end
        RINGING: begin
          // Buttons take priority over a coincident tick; stop beats snooze.
          if (stop_rise) begin
            state_d    = ARMED;
            ring_cnt_d = '0;
            left_d     = LeftLoad;
          end else if (snooze_rise && (left_q != '0)) begin
            state_d    = SNOOZE;
            snz_cnt_d  = SnzLoad;
            left_d     = left_q - 1'b1;
          end else if (sec_tick) begin
            if (ring_cnt_q == RingLast) begin
              state_d    = ARMED;
              ring_cnt_d = '0;
              left_d     = LeftLoad;
            end else begin
              ring_cnt_d = ring_cnt_q + 1'b1;
            end
          end
        end
        SNOOZE: begin
          if (stop_rise) begin
            state_d   = ARMED;
            snz_cnt_d = '0;
            left_d    = LeftLoad;
          end else if (sec_tick) begin
            if (snz_cnt_q == SnzLast) begin
              state_d    = RINGING;
              snz_cnt_d  = '0;
              ring_cnt_d = '0;
            end else begin
              snz_cnt_d = snz_cnt_q - 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    ring_d     = (state_d == RINGING);
    snoozing_d = (state_d == SNOOZE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      left_q     <= LeftLoad;
      match_q    <= 1'b1;
      ring_q     <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      left_q     <= left_d;
      match_q    <= match_d;
      ring_q     <= ring_d;
      snoozing_q <= snoozing_d;
    end
  end

  assign ring         = ring_q;
  assign snoozing     = snoozing_q;
  assign snoozes_left = left_q;

endmodule
